// File: rtl/seven_seg_scan_decoder_if.sv
// seven_seg_scan_decoder_if
//   Pin-level bundle between a multiplexed 7-segment display (or its driver)
//   and the scan decoder that monitors it.
//   master : drives the display lines and observes the decoded results.
//   slave  : the decoder; samples the display lines and drives the results.
//   Signals
//     an_n        anode enables, active-low, bit i = digit i
//     seg_n       segments {g,f,e,d,c,b,a}, active-low
//     value       last complete frame, digit i at [4i+3:4i]
//     frame_valid one-cycle pulse when value updates
//     pattern_err one-cycle pulse on a stable pattern outside the decode table
//     multi_err   one-cycle pulse when more than one anode is active
//   Macro SEVEN_SEG_DECODE_DP_EN adds dp_n (decimal point, active-low) and
//   value_dp (per-digit decimal point of the last complete frame).
interface seven_seg_scan_decoder_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic [NUM_DIGITS-1:0]   an_n;
    logic [6:0]              seg_n;
    logic [4*NUM_DIGITS-1:0] value;
    logic                    frame_valid;
    logic                    pattern_err;
    logic                    multi_err;
`ifdef SEVEN_SEG_DECODE_DP_EN
    logic                    dp_n;
    logic [NUM_DIGITS-1:0]   value_dp;

    modport master (
        output an_n, seg_n, dp_n,
        input  value, frame_valid, pattern_err, multi_err, value_dp
    );
    modport slave (
        input  an_n, seg_n, dp_n,
        output value, frame_valid, pattern_err, multi_err, value_dp
    );
`else
    modport master (
        output an_n, seg_n,
        input  value, frame_valid, pattern_err, multi_err
    );
    modport slave (
        input  an_n, seg_n,
        output value, frame_valid, pattern_err, multi_err
    );
`endif
endinterface

// File: rtl/seven_seg_scan_decoder.sv
// seven_seg_scan_decoder
//   Receive-side counterpart of the multiplexed 7-segment display driver.
//   Synchronises the scanned anode/segment lines, waits for each digit
//   pattern to be stable for STABLE_CYCLES samples, decodes it back to a
//   hex nibble and reports every complete frame (all digits seen) as one
//   packed value.
//   Parameters
//     NUM_DIGITS     number of scanned digits, 1..8
//     STABLE_CYCLES  identical synced samples needed to accept a digit, >=1
//   Ports
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    seven_seg_scan_decoder_if slave modport (an_n, seg_n in;
//            value, frame_valid, pattern_err, multi_err out)
//   Macro SEVEN_SEG_DECODE_DP_EN: adds dp_n input and value_dp output; the
//   decimal point takes part in the stability compare and is captured per
//   digit, but never raises pattern_err.
module seven_seg_scan_decoder #(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input logic                     clk,
    input logic                     rst_n,
    seven_seg_scan_decoder_if.slave bus
);
    localparam int unsigned CW = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
`ifdef SEVEN_SEG_DECODE_DP_EN
    localparam int unsigned PW = NUM_DIGITS + 8;
`else
    localparam int unsigned PW = NUM_DIGITS + 7;
`endif

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    // Synchroniser flops hold the inverted (active-high) lines, so their
    // reset value of 0 reads as "no anode active" rather than "all active".
    logic [NUM_DIGITS-1:0]   an_s1, an;
    logic [6:0]              seg_s1, seg;
    logic [PW-1:0]           samp;

    state_t                  state_q, state_d;
    logic [PW-1:0]           latch_q, latch_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    changed, multi, capture, multi_evt;

    logic [4:0]              dec;
    logic                    cap_ok, cap_bad, frame_done;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d, value_q;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d;
    logic                    frame_valid_q, pattern_err_q, multi_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_s1  <= '0;
            an     <= '0;
            seg_s1 <= '0;
            seg    <= '0;
        end else begin
            an_s1  <= ~bus.an_n;
            an     <= an_s1;
            seg_s1 <= ~bus.seg_n;
            seg    <= seg_s1;
        end
    end

`ifdef SEVEN_SEG_DECODE_DP_EN
    logic                  dp_s1, dp;
    logic [NUM_DIGITS-1:0] dps_q, dps_d, value_dp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_s1 <= 1'b0;
            dp    <= 1'b0;
        end else begin
            dp_s1 <= ~bus.dp_n;
            dp    <= dp_s1;
        end
    end

    assign samp = {dp, an, seg};
`else
    assign samp = {an, seg};
`endif

    // Returns {valid, nibble}; blank is accepted as 0.
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'h00, 7'h3F: decode = {1'b1, 4'h0};
            7'h06:        decode = {1'b1, 4'h1};
            7'h5B:        decode = {1'b1, 4'h2};
            7'h4F:        decode = {1'b1, 4'h3};
            7'h66:        decode = {1'b1, 4'h4};
            7'h6D:        decode = {1'b1, 4'h5};
            7'h7D:        decode = {1'b1, 4'h6};
            7'h07:        decode = {1'b1, 4'h7};
            7'h7F:        decode = {1'b1, 4'h8};
            7'h6F:        decode = {1'b1, 4'h9};
            7'h77:        decode = {1'b1, 4'hA};
            7'h7C:        decode = {1'b1, 4'hB};
            7'h39:        decode = {1'b1, 4'hC};
            7'h5E:        decode = {1'b1, 4'hD};
            7'h79:        decode = {1'b1, 4'hE};
            7'h71:        decode = {1'b1, 4'hF};
            default:      decode = 5'h00;
        endcase
    endfunction

    assign multi   = |(an & (an - NUM_DIGITS'(1)));
    assign changed = (samp != latch_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            latch_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            latch_q <= latch_d;
            cnt_q   <= cnt_d;
        end
    end

    // The latch also records zero/multi-anode samples while idle, so a
    // persistent multi-anode pattern raises multi_err only once.
    always_comb begin
        state_d   = state_q;
        latch_d   = latch_q;
        cnt_d     = cnt_q;
        capture   = 1'b0;
        multi_evt = 1'b0;
        if (state_q == SETTLE && !changed) begin
            if (cnt_q + CW'(1) == CW'(STABLE_CYCLES)) begin
                capture = 1'b1;
                state_d = HOLD;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (state_q == HOLD && !changed) begin
            state_d = HOLD;
        end else begin
            latch_d = samp;
            if (an == '0) begin
                state_d = IDLE;
            end else if (multi) begin
                state_d   = IDLE;
                multi_evt = changed;
            end else begin
                cnt_d = CW'(1);
                if (STABLE_CYCLES == 1) begin
                    capture = 1'b1;
                    state_d = HOLD;
                end else begin
                    state_d = SETTLE;
                end
            end
        end
    end

    // On a capture the live sample equals the accepted pattern, so it is
    // used directly (it also covers STABLE_CYCLES=1 where latch is stale).
    always_comb begin
        dec      = decode(seg);
        cap_ok   = capture & dec[4];
        cap_bad  = capture & ~dec[4];
        digits_d = digits_q;
        seen_d   = seen_q;
`ifdef SEVEN_SEG_DECODE_DP_EN
        dps_d    = dps_q;
`endif
        if (cap_ok) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (an[i]) begin
                    digits_d[4*i +: 4] = dec[3:0];
                    seen_d[i]          = 1'b1;
`ifdef SEVEN_SEG_DECODE_DP_EN
                    dps_d[i]           = dp;
`endif
                end
            end
        end
        frame_done = cap_ok & (&seen_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_q      <= '0;
            seen_q        <= '0;
            value_q       <= '0;
            frame_valid_q <= 1'b0;
            pattern_err_q <= 1'b0;
            multi_err_q   <= 1'b0;
        end else begin
            digits_q      <= digits_d;
            seen_q        <= frame_done ? '0 : seen_d;
            if (frame_done) begin
                value_q <= digits_d;
            end
            frame_valid_q <= frame_done;
            pattern_err_q <= cap_bad;
            multi_err_q   <= multi_evt;
        end
    end

`ifdef SEVEN_SEG_DECODE_DP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dps_q      <= '0;
            value_dp_q <= '0;
        end else begin
            dps_q <= dps_d;
            if (frame_done) begin
                value_dp_q <= dps_d;
            end
        end
    end

    assign bus.value_dp = value_dp_q;
`endif

    assign bus.value       = value_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.pattern_err = pattern_err_q;
    assign bus.multi_err   = multi_err_q;
endmodule
